pcpu_dmem_ctrl: RTL and testbench

Data-memory responder for the pipelined CPU's MEM stage: it accepts the load/store requests produced by the control unit (MemRead/MemWrite plus access size and sign mode) and executes them against a single-port, word-wide synchronous SRAM. The SRAM has no byte enables, so byte and halfword stores are done as read-modify-write. Sign/zero extension of loaded data is done here. `stall` holds the pipeline while an access is in flight.

---
 rtl/pcpu_dmem_ctrl_if.sv | 35 +++
 rtl/pcpu_dmem_ctrl.sv | 157 +++++++++++++++
 tb/tb_pcpu_dmem_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pcpu_dmem_ctrl_if.sv
// Bus bundle for the MEM-stage data-memory controller.
// Two groups of signals share this bundle:
//   - the CPU request/response signals;
//   - the single-port synchronous SRAM port.
// The slave modport is the controller itself. The master modport is
// everything around it: the pipeline that issues requests and the SRAM
// that returns ram_rdata.
interface pcpu_dmem_ctrl_if #(
  parameter int AW = 10
);
  logic          mem_rd;
  logic          mem_wr;
  logic [1:0]    mem_size;
  logic          mem_unsigned;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          stall;
  logic          err;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  modport slave (
    input  mem_rd, mem_wr, mem_size, mem_unsigned, addr, wdata, ram_rdata,
    output rdata, stall, err, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output mem_rd, mem_wr, mem_size, mem_unsigned, addr, wdata, ram_rdata,
    input  rdata, stall, err, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/pcpu_dmem_ctrl.sv
// Data-memory responder for the CPU MEM stage.
// Executes loads and stores against a word-wide synchronous SRAM that has
// no byte enables:
//   - word stores complete in one cycle;
//   - loads take one extra cycle;
//   - byte and halfword stores take one extra cycle as read-modify-write.
// Optional build macro PCPU_DMEM_ALIGN_CHECK_EN: when defined, misaligned
// halfword and word requests are rejected like illegal ones. When it is
// undefined, such requests are force-aligned and proceed.
module pcpu_dmem_ctrl #(
  parameter int AW = 10
) (
  input logic              clk,
  input logic              rstn,
  pcpu_dmem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR} state_t;

  state_t        state_q, state_d;
  logic [31:0]   hold_q;
  logic [AW-1:0] word_addr;
  logic          req, misalign, illegal;
  logic [31:0]   load_ext, merged;
  logic          en, we, stall, err;
  logic [31:0]   wd, rd_out;
  logic [AW-1:0] ram_addr;
  logic          unused_addr_bits;

  // Bits above the SRAM range are ignored, so the address wraps.
  assign word_addr        = bus.addr[AW+1:2];
  assign unused_addr_bits = ^bus.addr[31:AW+2];
  assign req              = bus.mem_rd | bus.mem_wr;

`ifdef PCPU_DMEM_ALIGN_CHECK_EN
  assign misalign = ((bus.mem_size == 2'b01) && bus.addr[0]) ||
                    ((bus.mem_size == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
  // Misaligned halfword/word requests are force-aligned.
  // Halfword lanes only look at addr[1]; words ignore addr[1:0].
  assign misalign = 1'b0;
`endif

  assign illegal = req && ((bus.mem_rd && bus.mem_wr) ||
                           (bus.mem_size == 2'b11) || misalign);

  // Select the addressed lane of the SRAM word and extend it to 32 bits.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    // NOTE: every variable assigned in a combinational block gets a value
    // on every path (defaults first); otherwise a latch is inferred.
    b = 8'h00;
    h = 16'h0000;
    load_ext = bus.ram_rdata;
    case (bus.mem_size)
      2'b00: begin
        case (bus.addr[1:0])
          2'd0:    b = bus.ram_rdata[7:0];
          2'd1:    b = bus.ram_rdata[15:8];
          2'd2:    b = bus.ram_rdata[23:16];
          default: b = bus.ram_rdata[31:24];
        endcase
        load_ext = bus.mem_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        h = bus.addr[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        load_ext = bus.mem_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: load_ext = bus.ram_rdata;
    endcase
  end

  // Merge the store data into the addressed lanes of the word just read.
  always_comb begin
    merged = bus.ram_rdata;
    if (bus.mem_size == 2'b00) begin
      case (bus.addr[1:0])
        2'd0:    merged[7:0]   = bus.wdata[7:0];
        2'd1:    merged[15:8]  = bus.wdata[7:0];
        2'd2:    merged[23:16] = bus.wdata[7:0];
        default: merged[31:24] = bus.wdata[7:0];
      endcase
    end else if (bus.addr[1]) begin
      merged[31:16] = bus.wdata[15:0];
    end else begin
      merged[15:0] = bus.wdata[15:0];
    end
  end

  // Next state and SRAM/pipeline controls.
  always_comb begin
    state_d  = state_q;
    en       = 1'b0;
    we       = 1'b0;
    wd       = 32'h0;
    stall    = 1'b0;
    err      = 1'b0;
    ram_addr = '0;
    rd_out   = hold_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          ram_addr = word_addr;
          if (illegal) begin
            err = 1'b1;
          end else if (bus.mem_wr && (bus.mem_size == 2'b10)) begin
            en = 1'b1;
            we = 1'b1;
            wd = bus.wdata;
          end else begin
            en      = 1'b1;
            stall   = 1'b1;
            state_d = bus.mem_rd ? RD_WAIT : RMW_WR;
          end
        end
      end
      RD_WAIT: begin
        ram_addr = word_addr;
        rd_out   = load_ext;
        state_d  = IDLE;
      end
      RMW_WR: begin
        ram_addr = word_addr;
        en       = 1'b1;
        we       = 1'b1;
        wd       = merged;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the SRAM strobes and pipeline outputs inactive immediately,
  // which also aborts a write that was due in RMW_WR.
  assign bus.ram_en    = en & rstn;
  assign bus.ram_we    = we & rstn;
  assign bus.ram_wdata = rstn ? wd : 32'h0;
  assign bus.ram_addr  = rstn ? ram_addr : '0;
  assign bus.stall     = stall & rstn;
  assign bus.err       = err & rstn;
  assign bus.rdata     = rd_out;

  // State register and load-result hold register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (!rstn) begin
      state_q <= IDLE;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_WAIT) hold_q <= load_ext;
    end
  end

endmodule

// File: tb/tb_pcpu_dmem_ctrl.sv
// Self-checking bench for pcpu_dmem_ctrl.
// A transaction-level model of the memory and the load-hold value predicts
// the expected outputs for every cycle. One compare process checks those
// predictions on each falling edge. Literal checks pin the model.
module tb_pcpu_dmem_ctrl;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pcpu_dmem_ctrl_if #(.AW(AW)) bus ();
  pcpu_dmem_ctrl #(.AW(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  logic [31:0] sram    [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] hold_m;
  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;

  // Expected outputs for the current cycle.
  logic          exp_valid = 1'b0;
  logic          exp_stall, exp_err, exp_en, exp_we, chk_zero;
  logic [31:0]   exp_rdata, exp_wdata;
  logic [AW-1:0] exp_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM behaviour with strobe counters.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        sram[bus.ram_addr] <= bus.ram_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        bus.ram_rdata <= sram[bus.ram_addr];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("stall", {31'h0, bus.stall}, {31'h0, exp_stall});
      check("err", {31'h0, bus.err}, {31'h0, exp_err});
      check("ram_en", {31'h0, bus.ram_en}, {31'h0, exp_en});
      check("ram_we", {31'h0, bus.ram_we}, {31'h0, exp_we});
      check("rdata", bus.rdata, exp_rdata);
      if (exp_en) check("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
      if (exp_we) check("ram_wdata", bus.ram_wdata, exp_wdata);
      if (chk_zero) begin
        check("ram_addr_zero", 32'(bus.ram_addr), 32'h0);
        check("ram_wdata_zero", bus.ram_wdata, 32'h0);
      end
    end
  end

  task automatic set_exp(input logic st, er, en, we, cz, input logic [31:0] rd,
                         input logic [AW-1:0] ad, input logic [31:0] wd);
    exp_stall = st; exp_err = er; exp_en = en; exp_we = we; chk_zero = cz;
    exp_rdata = rd; exp_addr = ad; exp_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_size = 2'b00;
    bus.mem_unsigned = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    set_exp(0, 0, 0, 0, 1, hold_m, '0, 32'h0);
    repeat (n) next_cycle();
  endtask

  // One request, presented at posedge+1. Returns at posedge+1 of the cycle
  // after it completes. The caller must immediately present the next
  // request or go idle.
  task automatic access(input logic rd, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    logic [AW-1:0] wa;
    logic          bad;
    logic [31:0]   w, mask, val;
    int            sh;
    wa  = a[AW+1:2];
    bad = (rd && wr) || (size == 2'b11);
`ifdef PCPU_DMEM_ALIGN_CHECK_EN
    if ((size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00)) bad = 1'b1;
`endif
    if (size == 2'b00) begin sh = 8 * int'(a[1:0]); mask = 32'hFF; end
    else begin sh = 16 * int'(a[1]); mask = 32'hFFFF; end
    bus.mem_rd = rd; bus.mem_wr = wr; bus.mem_size = size;
    bus.mem_unsigned = uns; bus.addr = a; bus.wdata = wd;
    if (bad) begin
      set_exp(0, 1, 0, 0, 0, hold_m, wa, 32'h0);
      next_cycle();
    end else if (wr && size == 2'b10) begin
      set_exp(0, 0, 1, 1, 0, hold_m, wa, wd);
      ref_mem[wa] = wd;
      next_cycle();
    end else begin
      set_exp(1, 0, 1, 0, 0, hold_m, wa, 32'h0);
      next_cycle();
      w = ref_mem[wa];
      if (rd) begin
        if (size == 2'b10) val = w;
        else begin
          val = (w >> sh) & mask;
          if (!uns && ((size == 2'b00) ? val[7] : val[15])) val = val | ~mask;
        end
        hold_m = val;
        set_exp(0, 0, 0, 0, 0, val, wa, 32'h0);
      end else begin
        val = (w & ~(mask << sh)) | ((wd & mask) << sh);
        ref_mem[wa] = val;
        set_exp(0, 0, 1, 1, 0, hold_m, wa, val);
      end
      next_cycle();
    end
  endtask

  initial begin
    int r0, w0;
    rstn = 1'b0;
    hold_m = 32'h0;
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_size = 2'b00;
    bus.mem_unsigned = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    set_exp(0, 0, 0, 0, 1, 32'h0, '0, 32'h0);
    exp_valid = 1'b1;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
    idle(1);

    // Word store, then word load.
    access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0);
    check("lw_0x10", bus.rdata, 32'hDEADBEEF);

    // Byte loads, signed and unsigned.
    access(0, 1, 2'b10, 0, 32'h20, 32'h803456F0);
    access(1, 0, 2'b00, 0, 32'h23, 32'h0);
    check("lb_0x23", bus.rdata, 32'hFFFFFF80);
    access(1, 0, 2'b00, 1, 32'h23, 32'h0);
    check("lbu_0x23", bus.rdata, 32'h00000080);

    // Halfword store by read-modify-write.
    access(0, 1, 2'b10, 0, 32'h20, 32'hAAAAAAAA);
    r0 = rd_cnt; w0 = wr_cnt;
    access(0, 1, 2'b01, 0, 32'h22, 32'h00001234);
    check("sh_reads", rd_cnt - r0, 1);
    check("sh_writes", wr_cnt - w0, 1);
    access(1, 0, 2'b10, 0, 32'h20, 32'h0);
    check("sh_result", bus.rdata, 32'h1234AAAA);

    // Back-to-back load then byte store.
    w0 = wr_cnt;
    access(1, 0, 2'b10, 0, 32'h10, 32'h0);
    access(0, 1, 2'b00, 0, 32'h11, 32'hFFFFFF55);
    check("b2b_writes", wr_cnt - w0, 1);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0);
    check("sb_result", bus.rdata, 32'hDEAD55EF);

    // Halfword loads.
    access(1, 0, 2'b01, 0, 32'h12, 32'h0);
    check("lh_0x12", bus.rdata, 32'hFFFFDEAD);
    access(1, 0, 2'b01, 1, 32'h12, 32'h0);
    check("lhu_0x12", bus.rdata, 32'h0000DEAD);

    // Illegal requests leave the hold value alone.
    access(1, 1, 2'b10, 0, 32'h10, 32'h0);
    access(1, 0, 2'b11, 0, 32'h10, 32'h0);
    check("illegal_hold", bus.rdata, 32'h0000DEAD);

    // Misaligned word load.
    access(1, 0, 2'b10, 0, 32'h13, 32'h0);
`ifdef PCPU_DMEM_ALIGN_CHECK_EN
    check("lw_0x13", bus.rdata, 32'h0000DEAD);
`else
    check("lw_0x13", bus.rdata, 32'hDEAD55EF);
`endif
    access(1, 0, 2'b01, 0, 32'h13, 32'h0);

    // High address bits wrap.
    access(1, 0, 2'b10, 0, 32'h10000020, 32'h0);
    check("lw_wrap", bus.rdata, 32'h1234AAAA);

    // Reset during RMW_WR aborts the write.
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b1; bus.mem_size = 2'b00;
    bus.mem_unsigned = 1'b0; bus.addr = 32'h21; bus.wdata = 32'h77;
    set_exp(1, 0, 1, 0, 0, hold_m, 10'h8, 32'h0);
    next_cycle();
    w0 = wr_cnt;
    rstn = 1'b0;
    hold_m = 32'h0;
    set_exp(0, 0, 0, 0, 1, 32'h0, '0, 32'h0);
    next_cycle();
    check("rst_no_write", wr_cnt - w0, 0);
    idle(1);
    rstn = 1'b1;
    idle(2);

    check("mem_0x10", sram[4], ref_mem[4]);
    check("mem_0x20", sram[8], ref_mem[8]);
    check("mem_0x20_lit", sram[8], 32'h1234AAAA);
    check("mem_0x10_lit", sram[4], 32'hDEAD55EF);

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
